// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN calculator execute stage: instruction fields,
// error codes and the execute FSM states.
package rpn_pkg;

    typedef enum logic [1:0] {
        CLS_PUSH  = 2'b00,
        CLS_ALU   = 2'b01,
        CLS_STACK = 2'b10,
        CLS_NOP   = 2'b11
    } instr_class_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_NOT = 3'b110,
        ALU_ILL = 3'b111
    } alu_func_e;

    typedef enum logic [1:0] {
        STK_DUP   = 2'b00,
        STK_DROP  = 2'b01,
        STK_SWAP  = 2'b10,
        STK_CLEAR = 2'b11
    } stack_func_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_ILLEGAL   = 2'b11
    } err_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    function automatic logic alu_is_unary(input logic [2:0] func);
        return alu_func_e'(func) == ALU_NOT;
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN execute stage: a is the second-from-top
// operand, b is the top; NOT acts on b alone.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        func,
    output logic [DATA_W-1:0] y,
    output logic              illegal
);

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (alu_func_e'(func))
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_MUL: y = a * b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rpn_stack_exec.sv
// RPN calculator execute stage: accepts one instruction per handshake and
// applies push/ALU/stack operations to a register-based operand LIFO.
module rpn_stack_exec
    import rpn_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [9:0]        instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_data,
    output logic [DATA_W-1:0] next_data,
    output logic [CNT_W-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    state_e            state_q, state_d;
    logic [9:0]        instr_q, instr_d;
    logic [CNT_W-1:0]  sp_q, sp_d;
    logic [DATA_W-1:0] stack_q [DEPTH];
    logic [DATA_W-1:0] stack_d [DEPTH];
    logic              err_q, err_d;
    err_code_e         err_code_q, err_code_d;

    logic [IDX_W-1:0]  top_idx, next_idx, push_idx;
    logic [DATA_W-1:0] top_val, next_val;
    logic [DATA_W-1:0] alu_y;
    logic              alu_illegal;
    err_code_e         new_err;

    // Indices are truncated to the array range; they are only used when the
    // depth guard for the operation holds.
    assign top_idx  = IDX_W'(sp_q - ONE);
    assign next_idx = IDX_W'(sp_q - TWO);
    assign push_idx = IDX_W'(sp_q);
    assign top_val  = stack_q[top_idx];
    assign next_val = stack_q[next_idx];

    rpn_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a       (next_val),
        .b       (top_val),
        .func    (instr_q[2:0]),
        .y       (alu_y),
        .illegal (alu_illegal)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_d = ST_EXEC;
                    instr_d = instr;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sp_d    = sp_q;
        stack_d = stack_q;
        new_err = ERR_NONE;
        if (state_q == ST_EXEC) begin
            case (instr_class_e'(instr_q[9:8]))
                CLS_PUSH: begin
                    if (sp_q == FULL_CNT) begin
                        new_err = ERR_OVERFLOW;
                    end else begin
                        stack_d[push_idx] = DATA_W'(instr_q[7:0]);
                        sp_d              = sp_q + ONE;
                    end
                end
                CLS_ALU: begin
                    if (alu_illegal) begin
                        new_err = ERR_ILLEGAL;
                    end else if (alu_is_unary(instr_q[2:0])) begin
                        if (sp_q == '0) new_err = ERR_UNDERFLOW;
                        else            stack_d[top_idx] = alu_y;
                    end else if (sp_q < TWO) begin
                        new_err = ERR_UNDERFLOW;
                    end else begin
                        stack_d[next_idx] = alu_y;
                        sp_d              = sp_q - ONE;
                    end
                end
                CLS_STACK: begin
                    case (stack_func_e'(instr_q[1:0]))
                        STK_DUP: begin
                            if (sp_q == '0) begin
                                new_err = ERR_UNDERFLOW;
                            end else if (sp_q == FULL_CNT) begin
                                new_err = ERR_OVERFLOW;
                            end else begin
                                stack_d[push_idx] = top_val;
                                sp_d              = sp_q + ONE;
                            end
                        end
                        STK_DROP: begin
                            if (sp_q == '0) new_err = ERR_UNDERFLOW;
                            else            sp_d = sp_q - ONE;
                        end
                        STK_SWAP: begin
                            if (sp_q < TWO) begin
                                new_err = ERR_UNDERFLOW;
                            end else begin
                                stack_d[top_idx]  = next_val;
                                stack_d[next_idx] = top_val;
                            end
                        end
                        default: sp_d = '0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // A coincident clear releases the held code so a new error is recorded.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (new_err != ERR_NONE) begin
            err_d = 1'b1;
            if (!err_q || err_clr) err_code_d = new_err;
        end else if (err_clr) begin
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            sp_q       <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            stack_q    <= stack_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign done        = (state_q == ST_EXEC);
    assign top_data    = (sp_q >= ONE) ? top_val : '0;
    assign next_data   = (sp_q >= TWO) ? next_val : '0;
    assign depth       = sp_q;
    assign empty       = (sp_q == '0);
    assign full        = (sp_q == FULL_CNT);
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
